fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined MIPS-style core. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned word into the IF/ID pipeline register. It applies redirects (branch, j, jr) requested by the decode stage, and supports stall and flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC and IF/ID contents
- redirect  input  1  decode stage requests a PC change this cycle
- pc_src  input  2  redirect kind: 2'b01 branch, 2'b10 j, 2'b11 jr; 2'b00 is illegal while redirect=1 and treated as no redirect
- br_off  input  32  sign-extended 16-bit branch immediate, in words
- j_idx  input  26  jump index field of the instruction in IF/ID
- jr_tgt  input  32  register value for jr
- imem_adr  output  32  byte address to instruction memory; equals pc
- imem_data  input  32  instruction word, combinational from imem_adr
- if_id_inst  output  32  registered instruction
- if_id_pc4  output  32  registered address of that instruction + 4
- if_id_valid  output  1  IF/ID holds a real fetched instruction
- fetch_count  output  32  number of instructions accepted into IF/ID
- misalign_err  output  1  sticky; jr target misaligned (FETCH_MISALIGN_TRAP_EN only, else tied 0)

## Operation
- Redirect targets use if_id_pc4, the PC+4 of the instruction being decoded:
  - branch = if_id_pc4 + (br_off << 2)
  - j = {if_id_pc4[31:28], j_idx, 2'b00}
  - jr = jr_tgt
- Per-edge priority is reset > redirect > stall > sequential.
- Redirect:
  - pc <= target.
  - IF/ID <= {NOP_WORD, 0, valid=0}, which squashes the wrong-path word currently fetched. No delay slot.
  - fetch_count unchanged.
- Stall without redirect: pc, IF/ID and fetch_count all hold.
- Sequential:
  - pc <= pc + 4, with a 32-bit modulo wrap: 32'hFFFF_FFFC -> 0.
  - IF/ID <= {imem_data, pc+4, 1}.
  - fetch_count <= fetch_count + 1, wrapping modulo 2^32.
- Redirect and stall in the same cycle: the redirect is taken.
- pc_src=00 with redirect=1: the cycle behaves as if redirect=0.

## Timing
- Reset, asynchronous and immediate:
  - pc = RESET_PC
  - if_id_inst = NOP_WORD
  - if_id_pc4 = 0
  - if_id_valid = 0
  - fetch_count = 0
  - misalign_err = 0
- imem_adr = pc combinationally; the instruction memory has zero latency.
- Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty is 1 bubble. The target word appears in IF/ID 1 edge after the redirect edge.
- Reset deasserted mid-program restarts at RESET_PC. The first valid IF/ID entry appears on the first edge after rst_n rises, unless stall is high.
- stall held N cycles gives N cycles of identical outputs.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined, jr with jr_tgt[1:0] != 0:
  - redirect ignored and the cycle treated as stall
  - misalign_err set
  - misalign_err stays 1 until reset
  - once set, pc, IF/ID and fetch_count freeze until reset
- Not defined:
  - jr target used as {jr_tgt[31:2], 2'b00}
  - misalign_err constant 0
- Branch and j targets are always aligned by construction.

## Structure
- Shared package cpu_pkg holds:
  - PC_SRC_SEQ/BR/J/JR localparams (2'b00/01/10/11)
  - the NOP_WORD default
  - the instruction-word width constant
- One sub-module: next_pc_mux, purely combinational. It takes pc, if_id_pc4, pc_src, br_off, j_idx, jr_tgt and redirect, and returns next_pc and jr_misaligned.
- The top holds the PC, IF/ID, counter and sticky-error registers.

## Test plan
- Reset: rst_n low mid-cycle -> pc=0, if_id_valid=0 and if_id_inst=0 immediately; after release, 3 edges -> pc=12, fetch_count=3, if_id_pc4=12.
- jr: program with addi R1,R0,16 at 0 and jr R1 at 4; redirect=1, pc_src=11, jr_tgt=16 while if_id_pc4=8 -> next pc=16, if_id_valid=0 for 1 cycle, then if_id_inst = word at 16 with if_id_pc4=20.
- Branch: if_id_pc4=8, br_off=-2 -> pc=0; j with if_id_pc4=32'h1000_0004, j_idx=26'h3 -> pc=32'h1000_000C.
- Stall: stall=1 for 3 cycles at pc=8 -> pc, IF/ID and fetch_count unchanged; stall and redirect together (branch to 40) -> pc=40, bubble inserted.
- Wrap: RESET_PC=32'hFFFF_FFFC, 1 sequential edge -> pc=0, if_id_pc4=0.
- Misaligned jr, jr_tgt=18:
  - with FETCH_MISALIGN_TRAP_EN -> misalign_err=1 and pc frozen thereafter
  - without it -> pc=16, misalign_err=0

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS-style core: redirect source encodings, the
// instruction word width and the default NOP used to fill the IF/ID register.
package cpu_pkg;

  localparam int          INST_W           = 32;
  localparam logic [1:0]  PC_SRC_SEQ       = 2'b00;
  localparam logic [1:0]  PC_SRC_BR        = 2'b01;
  localparam logic [1:0]  PC_SRC_J         = 2'b10;
  localparam logic [1:0]  PC_SRC_JR        = 2'b11;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection for the fetch stage. Redirect targets are
// computed relative to the PC+4 held in IF/ID; the jr target is always word-aligned.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] br_off,
  input  logic [25:0] j_idx,
  input  logic [31:0] jr_tgt,
  input  logic        redirect,
  output logic [31:0] next_pc,
  output logic        jr_misaligned
);

  // Select the redirect target; an illegal pc_src of 00 falls back to sequential.
  always_comb begin
    next_pc = pc_plus4(pc);
    if (redirect) begin
      case (pc_src)
        PC_SRC_BR: next_pc = if_id_pc4 + {br_off[29:0], 2'b00};
        PC_SRC_J:  next_pc = {if_id_pc4[31:28], j_idx, 2'b00};
        PC_SRC_JR: next_pc = {jr_tgt[31:2], 2'b00};
        default:   next_pc = pc_plus4(pc);
      endcase
    end else begin
      next_pc = pc_plus4(pc);
    end
  end

  assign jr_misaligned = redirect && (pc_src == PC_SRC_JR) && (jr_tgt[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, fetch counter and redirect/stall handling.
// Optional FETCH_MISALIGN_TRAP_EN makes a misaligned jr a sticky, freezing error.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  pc_src,
  input  logic [31:0] br_off,
  input  logic [25:0] j_idx,
  input  logic [31:0] jr_tgt,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       next_pc_s;
  logic              jr_misaligned_s;
  logic              take_redir_s;
  logic              trap_s;
  logic              frozen_s;

  next_pc_mux u_next_pc_mux (
    .pc            (pc_q),
    .if_id_pc4     (pc4_q),
    .pc_src        (pc_src),
    .br_off        (br_off),
    .j_idx         (j_idx),
    .jr_tgt        (jr_tgt),
    .redirect      (redirect),
    .next_pc       (next_pc_s),
    .jr_misaligned (jr_misaligned_s)
  );

  assign take_redir_s = redirect && (pc_src != PC_SRC_SEQ);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q, err_d;

  assign trap_s   = jr_misaligned_s;
  assign frozen_s = err_q;
  assign err_d    = err_q | trap_s;

  // Sticky misaligned-jr flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign misalign_err = err_q;
`else
  logic unused_misalign_s;

  assign unused_misalign_s = jr_misaligned_s;
  assign trap_s            = 1'b0;
  assign frozen_s          = 1'b0;
  assign misalign_err      = 1'b0;
`endif

  // Priority: frozen > redirect > stall (or trapped jr) > sequential fetch.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (frozen_s) begin
      pc_d = pc_q;
    end else if (take_redir_s && !trap_s) begin
      pc_d    = next_pc_s;
      inst_d  = NOP_WORD;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall || trap_s) begin
      pc_d = pc_q;
    end else begin
      pc_d    = pc_plus4(pc_q);
      inst_d  = imem_data;
      pc4_d   = pc_plus4(pc_q);
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  // PC, IF/ID and fetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_WORD;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_adr    = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_count = cnt_q;

endmodule
